mem_stage_param: RTL and testbench

Parametrised next-generation MEM pipeline stage for the pipelined RISC-V core, sitting between EX and WB. It does the following:
- Latches one EX op per handshake.
- Drives the memory request and response channels.
- Does store alignment and strobe generation internally from the raw address and size.
- Extracts and extends load data.
- Detects misaligned accesses.
- Presents a WB payload and an ID bypass.

---
 rtl/mem_stage_param_pkg.sv | 35 +++
 rtl/mem_stage_param_lane_align.sv | 62 ++++++
 rtl/mem_stage_param.sv | 196 +++++++++++++++++++
 tb/tb_mem_stage_param.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_param_pkg.sv
// Shared encodings for the parametrised MEM stage: access sizes, one-hot FSM states,
// the XLEN-dependent byte-offset width macro and the misalignment rule.
`ifndef MEM_STAGE_OFF_W
`define MEM_STAGE_OFF_W(xlen) (((xlen) == 64) ? 3 : 2)
`endif

package mem_stage_param_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_RESP = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

  // Double accesses only exist on a 64-bit datapath; elsewhere they are illegal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low,
                                         input logic is64);
    logic mis_s;
    case (size)
      SIZE_B:  mis_s = 1'b0;
      SIZE_H:  mis_s = low[0];
      SIZE_W:  mis_s = |low[1:0];
      SIZE_D:  mis_s = is64 ? (|low) : 1'b1;
      default: mis_s = 1'b1;
    endcase
    return mis_s;
  endfunction

endpackage

// File: rtl/mem_stage_param_lane_align.sv
// mem_lane_align: combinational store lane replication/strobes and load extract/extend.
module mem_lane_align #(
  parameter int XLEN = 32
) (
  input  logic [1:0]                       size,
  input  logic [`MEM_STAGE_OFF_W(XLEN)-1:0] offset,
  input  logic                             is_unsigned,
  input  logic [XLEN-1:0]                  sdata,
  input  logic [XLEN-1:0]                  rdata,
  output logic [XLEN-1:0]                  wdata,
  output logic [XLEN/8-1:0]                wstrb,
  output logic [XLEN-1:0]                  ldata
);
  import mem_stage_param_pkg::*;

  localparam int STRB_W = XLEN / 8;

  logic [XLEN-1:0] shifted_s;

  // Replicating the source across the word puts it in every lane, so the addressed lane is covered.
  always_comb begin
    wdata = sdata;
    wstrb = {STRB_W{1'b1}};
    case (size)
      SIZE_B: begin
        wdata = {STRB_W{sdata[7:0]}};
        wstrb = STRB_W'(1'b1) << offset;
      end
      SIZE_H: begin
        wdata = {(XLEN/16){sdata[15:0]}};
        wstrb = STRB_W'(2'b11) << offset;
      end
      SIZE_W: begin
        wdata = {(XLEN/32){sdata[31:0]}};
        wstrb = STRB_W'(4'hF) << offset;
      end
      SIZE_D: begin
        wdata = sdata;
        wstrb = {STRB_W{1'b1}};
      end
      default: begin
        wdata = sdata;
        wstrb = {STRB_W{1'b1}};
      end
    endcase
  end

  assign shifted_s = rdata >> {offset, 3'b000};

  // Load data: shift to bit 0, keep the accessed width, then sign- or zero-extend.
  always_comb begin
    ldata = shifted_s;
    case (size)
      SIZE_B:  ldata = is_unsigned ? XLEN'(shifted_s[7:0])  : XLEN'($signed(shifted_s[7:0]));
      SIZE_H:  ldata = is_unsigned ? XLEN'(shifted_s[15:0]) : XLEN'($signed(shifted_s[15:0]));
      SIZE_W:  ldata = is_unsigned ? XLEN'(shifted_s[31:0]) : XLEN'($signed(shifted_s[31:0]));
      SIZE_D:  ldata = shifted_s;
      default: ldata = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_stage_param.sv
// MEM pipeline stage between EX and WB: request/response handshakes, alignment, bypass.
// Optional performance counters are enabled with the MEM_STAGE_PERF_EN macro.
module mem_stage_param #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_sdata,
  input  logic [XLEN-1:0]   in_result,
  input  logic              in_rf_wen,
  input  logic [4:0]        in_rf_waddr,
  input  logic [XLEN-1:0]   in_pc,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_req_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_rf_wen,
  output logic [4:0]        out_rf_waddr,
  output logic [XLEN-1:0]   out_rf_wdata,
  output logic              out_misalign,
`ifdef MEM_STAGE_PERF_EN
  output logic [31:0]       perf_ld_cnt,
  output logic [31:0]       perf_st_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic              byp_valid,
  output logic              byp_is_load,
  output logic [4:0]        byp_waddr,
  output logic [XLEN-1:0]   byp_wdata
);
  import mem_stage_param_pkg::*;

  localparam int   STRB_W = XLEN / 8;
  localparam int   OFF_W  = `MEM_STAGE_OFF_W(XLEN);
  localparam logic IS64   = (XLEN == 64);

  state_e            state_r, state_nxt_s;
  logic              load_r, store_r, uns_r, rf_wen_r, mis_r;
  logic [1:0]        size_r;
  logic [4:0]        waddr_r;
  logic [XLEN-1:0]   addr_r, sdata_r, result_r, pc_r, rdata_r;
  logic              accept_s, in_mem_s, in_mis_s;
  logic [XLEN-1:0]   wdata_s, ldata_s, wb_data_s;
  logic [STRB_W-1:0] wstrb_s;

  assign in_ready = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
  assign accept_s = in_valid & in_ready;
  assign in_mem_s = in_load | in_store;
  assign in_mis_s = in_mem_s & is_misaligned(in_size, in_addr[2:0], IS64);

  // Next-state: DONE with a new op branches exactly like IDLE for zero-bubble issue.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          if (in_mem_s & ~in_mis_s) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else if ((state_r == ST_DONE) & out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_nxt_s = load_r ? ST_RESP : ST_DONE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State and payload registers; a reset mid-op also forgets any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      load_r   <= 1'b0;
      store_r  <= 1'b0;
      uns_r    <= 1'b0;
      rf_wen_r <= 1'b0;
      mis_r    <= 1'b0;
      size_r   <= 2'b00;
      waddr_r  <= 5'd0;
      addr_r   <= {XLEN{1'b0}};
      sdata_r  <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
      pc_r     <= {XLEN{1'b0}};
      rdata_r  <= {XLEN{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        load_r   <= in_load;
        store_r  <= in_store;
        uns_r    <= in_unsigned;
        rf_wen_r <= in_rf_wen;
        mis_r    <= in_mis_s;
        size_r   <= in_size;
        waddr_r  <= in_rf_waddr;
        addr_r   <= in_addr;
        sdata_r  <= in_sdata;
        result_r <= in_result;
        pc_r     <= in_pc;
      end
      if ((state_r == ST_RESP) & mem_rvalid) begin
        rdata_r <= mem_rdata;
      end
    end
  end

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .size        (size_r),
    .offset      (addr_r[OFF_W-1:0]),
    .is_unsigned (uns_r),
    .sdata       (sdata_r),
    .rdata       (rdata_r),
    .wdata       (wdata_s),
    .wstrb       (wstrb_s),
    .ldata       (ldata_s)
  );

  assign mem_addr   = {addr_r[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_read   = (state_r == ST_REQ) & load_r;
  assign mem_write  = (state_r == ST_REQ) & store_r;
  assign mem_wdata  = mem_write ? wdata_s : {XLEN{1'b0}};
  assign mem_wstrb  = mem_write ? wstrb_s : {STRB_W{1'b0}};
  assign mem_rready = (state_r == ST_RESP);

  assign wb_data_s    = (load_r & ~mis_r) ? ldata_s : result_r;
  assign out_valid    = (state_r == ST_DONE);
  assign out_pc       = pc_r;
  assign out_rf_wen   = rf_wen_r & ~mis_r;
  assign out_rf_waddr = waddr_r;
  assign out_rf_wdata = wb_data_s;
  assign out_misalign = mis_r;

  assign byp_valid   = (state_r != ST_IDLE) & rf_wen_r & ~mis_r;
  assign byp_is_load = load_r & ((state_r == ST_REQ) | (state_r == ST_RESP));
  assign byp_waddr   = waddr_r;
  assign byp_wdata   = wb_data_s;

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] ld_cnt_r, st_cnt_r, stall_cnt_r;
  logic        req_hs_s, stall_s;

  assign req_hs_s = (state_r == ST_REQ) & mem_req_ready;
  assign stall_s  = ((state_r == ST_REQ) & ~mem_req_ready) |
                    ((state_r == ST_RESP) & ~mem_rvalid) |
                    ((state_r == ST_DONE) & ~out_ready);

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_r    <= 32'd0;
      st_cnt_r    <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (req_hs_s & load_r)  ld_cnt_r    <= ld_cnt_r + 32'd1;
      if (req_hs_s & store_r) st_cnt_r    <= st_cnt_r + 32'd1;
      if (stall_s)            stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign perf_ld_cnt    = ld_cnt_r;
  assign perf_st_cnt    = st_cnt_r;
  assign perf_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_mem_stage_param.sv
// Self-checking bench for mem_stage_param (XLEN=32 main instance, XLEN=64 spot checks).
module tb_mem_stage_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic        rst;
  logic        in_valid, in_ready, in_load, in_store, in_unsigned, in_rf_wen;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_sdata, in_result, in_pc;
  logic [4:0]  in_rf_waddr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_req_ready, mem_rvalid, mem_rready;
  logic [3:0]  mem_wstrb;
  logic        out_valid, out_ready, out_rf_wen, out_misalign;
  logic [31:0] out_pc, out_rf_wdata;
  logic [4:0]  out_rf_waddr;
  logic        byp_valid, byp_is_load;
  logic [4:0]  byp_waddr;
  logic [31:0] byp_wdata;

  mem_stage_param #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_sdata(in_sdata),
    .in_result(in_result), .in_rf_wen(in_rf_wen), .in_rf_waddr(in_rf_waddr), .in_pc(in_pc),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rf_wen(out_rf_wen),
    .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata), .out_misalign(out_misalign),
    .byp_valid(byp_valid), .byp_is_load(byp_is_load), .byp_waddr(byp_waddr),
    .byp_wdata(byp_wdata)
  );

  logic        in_valid6, in_ready6, in_load6, in_store6, in_unsigned6, in_rf_wen6;
  logic [1:0]  in_size6;
  logic [63:0] in_addr6, in_sdata6, in_result6, in_pc6;
  logic [4:0]  in_rf_waddr6;
  logic [63:0] mem_addr6, mem_wdata6, mem_rdata6;
  logic        mem_read6, mem_write6, mem_req_ready6, mem_rvalid6, mem_rready6;
  logic [7:0]  mem_wstrb6;
  logic        out_valid6, out_ready6, out_rf_wen6, out_misalign6;
  logic [63:0] out_pc6, out_rf_wdata6;
  logic [4:0]  out_rf_waddr6;
  logic        byp_valid6, byp_is_load6;
  logic [4:0]  byp_waddr6;
  logic [63:0] byp_wdata6;

  mem_stage_param #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_load(in_load6), .in_store(in_store6),
    .in_size(in_size6), .in_unsigned(in_unsigned6), .in_addr(in_addr6), .in_sdata(in_sdata6),
    .in_result(in_result6), .in_rf_wen(in_rf_wen6), .in_rf_waddr(in_rf_waddr6), .in_pc(in_pc6),
    .mem_addr(mem_addr6), .mem_read(mem_read6), .mem_write(mem_write6), .mem_wdata(mem_wdata6),
    .mem_wstrb(mem_wstrb6), .mem_req_ready(mem_req_ready6), .mem_rdata(mem_rdata6),
    .mem_rvalid(mem_rvalid6), .mem_rready(mem_rready6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_pc(out_pc6), .out_rf_wen(out_rf_wen6),
    .out_rf_waddr(out_rf_waddr6), .out_rf_wdata(out_rf_wdata6), .out_misalign(out_misalign6),
    .byp_valid(byp_valid6), .byp_is_load(byp_is_load6), .byp_waddr(byp_waddr6),
    .byp_wdata(byp_wdata6)
  );

  task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] res, input logic wen, input logic [4:0] waddr,
                          input logic [31:0] pc);
    in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
    in_addr = addr; in_sdata = sdata; in_result = res; in_rf_wen = wen;
    in_rf_waddr = waddr; in_pc = pc;
  endtask

  task automatic scramble_inputs();
    in_valid = 1'b0; in_load = 1'($urandom); in_store = 1'($urandom);
    in_size = 2'($urandom); in_unsigned = 1'($urandom); in_addr = $urandom;
    in_sdata = $urandom; in_result = $urandom; in_rf_wen = 1'($urandom);
    in_rf_waddr = 5'($urandom); in_pc = $urandom;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %0h want 1", in_ready); else n_pass++;
    n_checks++; if ({out_valid, mem_read, mem_write, mem_rready, out_rf_wen, out_misalign, byp_valid, byp_is_load} !== 8'h00)
      $display("FAIL rst_ctrl got %0h want 0", {out_valid, mem_read, mem_write, mem_rready, out_rf_wen, out_misalign, byp_valid, byp_is_load}); else n_pass++;
    n_checks++; if ({mem_addr, mem_wdata, out_rf_wdata, out_pc, 4'(mem_wstrb)} !== 132'd0)
      $display("FAIL rst_data got %0h want 0", {mem_addr, mem_wdata, out_rf_wdata, out_pc}); else n_pass++;
    n_checks++; if ({in_ready6, out_valid6, mem_read6, mem_wstrb6} !== 11'b100_0000_0000)
      $display("FAIL rst_x64 got %0h want 400", {in_ready6, out_valid6, mem_read6, mem_wstrb6}); else n_pass++;
  endtask

  // One op through the XLEN=32 stage, checked against an arithmetic model of the rules.
  task automatic do_op32(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] res, input logic wen, input logic [4:0] waddr,
                         input logic [31:0] pc, input logic [31:0] rdata,
                         input int req_lat, input int resp_lat, input int hold);
    int nb, off, strb_i;
    logic mis_e, memop;
    logic [3:0]  exp_strb;
    logic [63:0] v;
    logic [31:0] exp_wd;
    nb = 1 << sz;
    off = int'(addr % 32'd4);
    memop = ld | st;
    mis_e = memop && (sz == 2'd3 || (addr % nb) != 0);
    strb_i = ((1 << nb) - 1) << off;
    exp_strb = strb_i[3:0];
    v = {32'd0, rdata} >> (8 * off);
    v = v & ((64'd1 << (8 * nb)) - 64'd1);
    if (!uns && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    exp_wd = (ld && !mis_e) ? v[31:0] : res;

    @(negedge clk);
    drive_op(ld, st, sz, uns, addr, sdata, res, wen, waddr, pc);
    out_ready = 1'b0; mem_req_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got %0h want 1", in_ready); else n_pass++;
    @(negedge clk);
    scramble_inputs();
    if (memop && !mis_e) begin
      for (int c = 0; c <= req_lat; c++) begin
        mem_req_ready = (c == req_lat);
        #1;
        n_checks++; if ({mem_read, mem_write} !== {ld, st}) $display("FAIL req_rw got %b want %b", {mem_read, mem_write}, {ld, st}); else n_pass++;
        n_checks++; if (mem_addr !== (addr & 32'hFFFF_FFFC)) $display("FAIL req_addr got %h want %h", mem_addr, addr & 32'hFFFF_FFFC); else n_pass++;
        n_checks++; if ({in_ready, out_valid, byp_is_load, byp_valid} !== {1'b0, 1'b0, ld, wen})
          $display("FAIL req_flags got %b want %b", {in_ready, out_valid, byp_is_load, byp_valid}, {1'b0, 1'b0, ld, wen}); else n_pass++;
        if (st) begin
          n_checks++; if (mem_wstrb !== exp_strb) $display("FAIL req_wstrb got %b want %b", mem_wstrb, exp_strb); else n_pass++;
          for (int i = 0; i < 4; i++) begin
            if (exp_strb[i]) begin
              n_checks++;
              if (mem_wdata[8*i +: 8] !== sdata[8*(i-off) +: 8])
                $display("FAIL req_lane%0d got %h want %h", i, mem_wdata[8*i +: 8], sdata[8*(i-off) +: 8]);
              else n_pass++;
            end
          end
        end
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      if (ld) begin
        for (int c = 0; c <= resp_lat; c++) begin
          mem_rvalid = (c == resp_lat);
          mem_rdata  = (c == resp_lat) ? rdata : $urandom;
          #1;
          n_checks++; if ({mem_rready, mem_read, out_valid, byp_is_load} !== 4'b1001)
            $display("FAIL resp_flags got %b want 1001", {mem_rready, mem_read, out_valid, byp_is_load}); else n_pass++;
          @(negedge clk);
        end
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
    end
    for (int c = 0; c <= hold; c++) begin
      #1;
      n_checks++; if ({out_valid, in_ready, mem_read, mem_write, byp_is_load} !== 5'b10000)
        $display("FAIL done_flags got %b want 10000", {out_valid, in_ready, mem_read, mem_write, byp_is_load}); else n_pass++;
      n_checks++; if ({out_misalign, out_rf_wen, byp_valid} !== {mis_e, wen && !mis_e, wen && !mis_e})
        $display("FAIL done_mis_wen got %b want %b", {out_misalign, out_rf_wen, byp_valid}, {mis_e, wen && !mis_e, wen && !mis_e}); else n_pass++;
      n_checks++; if ({out_pc, out_rf_waddr, byp_waddr} !== {pc, waddr, waddr})
        $display("FAIL done_pc_waddr got %h/%0d want %h/%0d", out_pc, out_rf_waddr, pc, waddr); else n_pass++;
      if (!st && !(ld && mis_e)) begin
        n_checks++; if (out_rf_wdata !== exp_wd) $display("FAIL done_wdata got %h want %h", out_rf_wdata, exp_wd); else n_pass++;
        n_checks++; if (byp_wdata !== exp_wd) $display("FAIL done_byp_wdata got %h want %h", byp_wdata, exp_wd); else n_pass++;
      end
      if (c < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL done_in_ready got %0h want 1", in_ready); else n_pass++;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL back_idle got %b want 01", {out_valid, in_ready}); else n_pass++;
  endtask

  task automatic test_store_byte();
    do_op32(1'b0, 1'b1, 2'b00, 1'b0, 32'h1003, 32'h0000_00AB, 32'h0, 1'b0, 5'd0, 32'h100, 32'h0, 0, 0, 0);
  endtask

  task automatic test_load_byte();
    do_op32(1'b1, 1'b0, 2'b00, 1'b0, 32'h2002, 32'h0, 32'h0, 1'b1, 5'd7, 32'h104, 32'h00F0_0000, 1, 3, 1);
    do_op32(1'b1, 1'b0, 2'b00, 1'b1, 32'h2002, 32'h0, 32'h0, 1'b1, 5'd8, 32'h108, 32'h00F0_0000, 0, 3, 0);
  endtask

  task automatic test_misalign();
    do_op32(1'b1, 1'b0, 2'b10, 1'b0, 32'h3002, 32'h0, 32'h55, 1'b1, 5'd9, 32'h10C, 32'h1234_5678, 0, 0, 0);
    do_op32(1'b1, 1'b0, 2'b11, 1'b0, 32'h3000, 32'h0, 32'h55, 1'b1, 5'd9, 32'h110, 32'h1234_5678, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b1;
    drive_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'hAAAA_0001, 1'b1, 5'd3, 32'h200);
    @(negedge clk);
    drive_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'hBBBB_0002, 1'b1, 5'd4, 32'h204);
    #1;
    n_checks++; if ({out_valid, in_ready, byp_valid} !== 3'b111) $display("FAIL b2b_a_flags got %b want 111", {out_valid, in_ready, byp_valid}); else n_pass++;
    n_checks++; if (out_rf_wdata !== 32'hAAAA_0001) $display("FAIL b2b_a_data got %h want aaaa0001", out_rf_wdata); else n_pass++;
    @(negedge clk);
    drive_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hC0DE_F00D, 32'h0, 1'b0, 5'd0, 32'h208);
    mem_req_ready = 1'b1;
    #1;
    n_checks++; if ({out_valid, out_rf_waddr} !== {1'b1, 5'd4}) $display("FAIL b2b_b_valid got %b want 1_00100", {out_valid, out_rf_waddr}); else n_pass++;
    n_checks++; if (out_rf_wdata !== 32'hBBBB_0002) $display("FAIL b2b_b_data got %h want bbbb0002", out_rf_wdata); else n_pass++;
    @(negedge clk);
    scramble_inputs();
    #1;
    n_checks++; if ({mem_write, out_valid, mem_wstrb} !== 6'b10_1111) $display("FAIL b2b_c_req got %b want 101111", {mem_write, out_valid, mem_wstrb}); else n_pass++;
    n_checks++; if (mem_wdata !== 32'hC0DE_F00D) $display("FAIL b2b_c_wdata got %h want c0def00d", mem_wdata); else n_pass++;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_c_done got %b want 1", out_valid); else n_pass++;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_midop_reset();
    @(negedge clk);
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 5'd5, 32'h300);
    mem_req_ready = 1'b0;
    @(negedge clk);
    scramble_inputs();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (mem_read !== 1'b1) $display("FAIL stall_read c%0d got %b want 1", c, mem_read); else n_pass++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if ({mem_read, in_ready, mem_rready, byp_valid} !== 4'b0100)
      $display("FAIL midrst_state got %b want 0100", {mem_read, in_ready, mem_rready, byp_valid}); else n_pass++;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    n_checks++; if ({out_valid, mem_rready, in_ready} !== 3'b001)
      $display("FAIL late_resp got %b want 001", {out_valid, mem_rready, in_ready}); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] kind;
    for (int n = 0; n < 40; n++) begin
      kind = 2'($urandom_range(0, 2));
      do_op32(kind == 2'd1, kind == 2'd2, 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
              $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  task automatic test_xlen64();
    @(negedge clk);
    in_valid6 = 1'b1; in_load6 = 1'b1; in_store6 = 1'b0; in_size6 = 2'b11; in_unsigned6 = 1'b0;
    in_addr6 = 64'h8; in_rf_wen6 = 1'b1; in_rf_waddr6 = 5'd10; in_pc6 = 64'h400;
    mem_req_ready6 = 1'b1; out_ready6 = 1'b0;
    @(negedge clk);
    in_valid6 = 1'b0;
    #1;
    n_checks++; if ({mem_read6, mem_addr6} !== {1'b1, 64'h8}) $display("FAIL x64_ld_req got %b/%h want 1/8", mem_read6, mem_addr6); else n_pass++;
    @(negedge clk);
    mem_req_ready6 = 1'b0; mem_rvalid6 = 1'b1; mem_rdata6 = 64'h8000_0000_0000_0001;
    #1;
    n_checks++; if (mem_rready6 !== 1'b1) $display("FAIL x64_rready got %b want 1", mem_rready6); else n_pass++;
    @(negedge clk);
    mem_rvalid6 = 1'b0; mem_rdata6 = 64'h0;
    #1;
    n_checks++; if ({out_valid6, out_rf_wen6} !== 2'b11) $display("FAIL x64_ld_done got %b want 11", {out_valid6, out_rf_wen6}); else n_pass++;
    n_checks++; if (out_rf_wdata6 !== 64'h8000_0000_0000_0001) $display("FAIL x64_ld_data got %h want 8000000000000001", out_rf_wdata6); else n_pass++;
    out_ready6 = 1'b1;
    in_valid6 = 1'b1; in_load6 = 1'b0; in_store6 = 1'b1; in_size6 = 2'b10;
    in_addr6 = 64'h4; in_sdata6 = 64'h1122_3344_DEAD_BEEF; in_rf_wen6 = 1'b0; mem_req_ready6 = 1'b1;
    @(negedge clk);
    in_valid6 = 1'b0; out_ready6 = 1'b0;
    #1;
    n_checks++; if ({mem_write6, mem_wstrb6} !== {1'b1, 8'hF0}) $display("FAIL x64_sw_strb got %b/%h want 1/f0", mem_write6, mem_wstrb6); else n_pass++;
    n_checks++; if ({mem_addr6, mem_wdata6[63:32]} !== {64'h0, 32'hDEAD_BEEF}) $display("FAIL x64_sw_data got %h/%h want 0/deadbeef", mem_addr6, mem_wdata6[63:32]); else n_pass++;
    @(negedge clk);
    mem_req_ready6 = 1'b0;
    #1;
    n_checks++; if ({out_valid6, out_rf_wen6, out_misalign6} !== 3'b100) $display("FAIL x64_sw_done got %b want 100", {out_valid6, out_rf_wen6, out_misalign6}); else n_pass++;
    out_ready6 = 1'b1;
    @(negedge clk);
    out_ready6 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'b00; in_unsigned = 1'b0;
    in_addr = 32'h0; in_sdata = 32'h0; in_result = 32'h0; in_rf_wen = 1'b0;
    in_rf_waddr = 5'd0; in_pc = 32'h0; mem_req_ready = 1'b0; mem_rdata = 32'h0;
    mem_rvalid = 1'b0; out_ready = 1'b0;
    in_valid6 = 1'b0; in_load6 = 1'b0; in_store6 = 1'b0; in_size6 = 2'b00; in_unsigned6 = 1'b0;
    in_addr6 = 64'h0; in_sdata6 = 64'h0; in_result6 = 64'h0; in_rf_wen6 = 1'b0;
    in_rf_waddr6 = 5'd0; in_pc6 = 64'h0; mem_req_ready6 = 1'b0; mem_rdata6 = 64'h0;
    mem_rvalid6 = 1'b0; out_ready6 = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_store_byte();
    test_load_byte();
    test_misalign();
    test_back_to_back();
    test_midop_reset();
    test_random();
    test_xlen64();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
